cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Common-data-bus arbiter for the Tomasulo back end. Sits between the functional
//  units (ALU, CMP, LD/ST reservation-station groups) and the single CDB that feeds
//  the ROB value/busy arrays and every RS operand tag comparator.
//  Each requester owns a 1-entry holding register. One held result is broadcast
//  per cycle, picked by round-robin. Losers are back-pressured via req_ready.
// PARAMETERS
//  NUM_REQ  3   number of requesters (0=ALU, 1=CMP, 2=LDST)
//  TAG_W    4   ROB tag width (tag_t); tag 0 = "no tag"
//  DATA_W   32  result width (rv32i_word)
// PORTS
//  clk        in   1               clock, all state updates on rising edge
//  rst        in   1               synchronous, active-high reset
//  flush      in   1               mispredict flush; drop all held/pending results
//  req_valid  in   NUM_REQ         requester i presents a result
//  req_tag    in   NUM_REQ*TAG_W   destination ROB tag, slice i = [i*TAG_W +: TAG_W]
//  req_data   in   NUM_REQ*DATA_W  result value, slice i = [i*DATA_W +: DATA_W]
//  req_ready  out  NUM_REQ         holding register i can accept this cycle
//  cdb_valid  out  1               broadcast valid (registered)
//  cdb_tag    out  TAG_W           broadcast ROB tag (registered)
//  cdb_data   out  DATA_W          broadcast value (registered)
//  cdb_src    out  $clog2(NUM_REQ) index of winning requester (registered)
// BEHAVIOUR
//  - Reset: held_v all 0, rr_last = NUM_REQ-1, so req 0 has first priority.
//    cdb_valid/tag/data/src = 0.
//  - Handshake: transfer on a rising edge where req_valid[i] & req_ready[i].
//    Data is loaded into holding register i, held_v[i] <= 1.
//  - req_ready[i] = !flush & (!held_v[i] | grant[i]). Combinational, no dependence
//    on req_valid. A granted entry can be refilled on the same edge.
//  - Arbitration is combinational over held_v only, never raw req_valid.
//    Search order: rr_last+1, rr_last+2, ... mod NUM_REQ; first held entry wins.
//    At most one grant per cycle.
//  - On a grant at edge E:
//    - cdb_valid <= 1; cdb_tag/data/src <= winner's held contents.
//    - held_v[winner] <= 0, unless refilled at E.
//    - rr_last <= winner.
//  - With no held entries: cdb_valid <= 0, rr_last unchanged.
//    cdb_tag/data/src hold their last value (don't-care).
//  - Latency: handshake at edge E -> cdb_valid high for exactly the cycle after E+1
//    if uncontended.
//    - Throughput: 1 broadcast/cycle total.
//    - A requester that is alone may stream 1 result/cycle.
//  - Fairness: with all NUM_REQ held continuously, grants rotate strictly.
//    Each requester waits at most NUM_REQ-1 cycles after becoming held.
//  - Tag 0: a handshake with tag 0 completes (ready honoured) but is discarded.
//    held_v is not set. Invariant: cdb_valid -> cdb_tag != 0.
//  - Flush (edge with flush=1):
//    - held_v all <= 0 and cdb_valid <= 0.
//    - No handshake completes (req_ready=0) and no grant takes effect.
//    - rr_last is unchanged.
//    - Flush has priority over every simultaneous event.
//  - rst dominates flush. Reset mid-stream discards all held results with no
//    partial broadcast.
//  - Holding-register contents change only on handshake. A held result is never
//    overwritten before it is granted.
// TESTING
//  1. Reset: after 1 cycle of rst=1 -> cdb_valid=0, req_ready=3'b111.
//     Idle for 5 cycles -> cdb_valid stays 0.
//  2. Single: req0 tag=3, data=0xDEADBEEF handshake at edge 5 ->
//     cycle after edge 6: cdb_valid=1, tag=3, data=0xDEADBEEF, src=0.
//     Cycle after edge 7: cdb_valid=0.
//  3. Contention: req0/1/2 (tags 1,2,3) all valid every cycle from reset ->
//     cdb_src sequence 0,1,2,0,1,2; no cycle without broadcast after the first.
//  4. Back-pressure: req0 and req1 held in same cycle, rr_last=2 -> req0 granted;
//     req_ready[1]=0 that cycle; req1 broadcast next cycle; req1 never lost.
//  5. Flush: req0 and req2 held, flush=1 at edge E -> cdb_valid=0 after E.
//     Neither tag is ever broadcast; req_ready=0 during flush cycle.
//  6. Tag 0: req1 tag=0, data=0x55 handshake -> no broadcast in next 4 cycles;
//     req_ready[1] remains 1.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Common-data-bus arbiter bus bundle.
//  master : requester side (functional units), drives flush/req_*, sees ready + CDB.
//  slave  : arbiter side, drives req_ready and the registered cdb_* broadcast.
//  req_tag/req_data are flat vectors; slice i = [i*W +: W].
interface cdb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic                      flush;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
  logic [SRC_W-1:0]          cdb_src;

  modport master (
    output flush, req_valid, req_tag, req_data,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    input  flush, req_valid, req_tag, req_data,
    output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter onto the single common data bus.
//  Each requester owns a 1-entry holding register (cdb_hold_lane). One held
//  result per cycle is broadcast on the registered cdb_* outputs; losers
//  back-pressure through req_ready.
//  Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (dominates flush)
//   bus  - cdb_arbiter_if.slave: flush, req_valid/tag/data in,
//          req_ready out, cdb_valid/tag/data/src out (registered)

// One holding register. Load and flush are mutually exclusive upstream
// (ready is forced low under flush), but flush is still given priority here.
module cdb_hold_lane #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,     // handshake with a non-zero tag
  input  logic              clear,    // this lane won the CDB this cycle
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_data,
  output logic              held_v,
  output logic [TAG_W-1:0]  tag,
  output logic [DATA_W-1:0] data
);
  always_ff @(posedge clk) begin
    if (rst) begin
      held_v <= 1'b0;
    end else if (flush) begin
      held_v <= 1'b0;
    end else if (load) begin
      // refill on the grant edge keeps the entry held with new contents
      held_v <= 1'b1;
      tag    <= in_tag;
      data   <= in_data;
    end else if (clear) begin
      held_v <= 1'b0;
    end
  end
endmodule

module cdb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic         clk,
  input  logic         rst,
  cdb_arbiter_if.slave bus
);
  logic [NUM_REQ-1:0]             held_v;
  logic [NUM_REQ-1:0][TAG_W-1:0]  held_tag;
  logic [NUM_REQ-1:0][DATA_W-1:0] held_data;
  logic [NUM_REQ-1:0]             grant;
  logic [NUM_REQ-1:0]             load;
  logic [SRC_W-1:0]               rr_last;
  logic [SRC_W-1:0]               win;
  logic                           found;

  // Round-robin search over held entries only, starting just after rr_last.
  always_comb begin
    logic [SRC_W-1:0] idx;
    idx   = '0;
    win   = '0;
    found = 1'b0;
    grant = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = SRC_W'((int'(rr_last) + k) % NUM_REQ);
      if (!found && held_v[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    // grant is suppressed under flush so nothing is consumed on that edge
    if (found && !bus.flush) grant[win] = 1'b1;
  end

  genvar i;
  generate
    for (i = 0; i < NUM_REQ; i++) begin : g_lane
      // ready never looks at req_valid; a granted entry may refill same edge
      assign bus.req_ready[i] = !bus.flush && (!held_v[i] || grant[i]);
      // tag 0 completes the handshake but is dropped on the floor
      assign load[i] = bus.req_valid[i] && bus.req_ready[i] &&
                       (bus.req_tag[i*TAG_W +: TAG_W] != '0);

      cdb_hold_lane #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_lane (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.flush),
        .load    (load[i]),
        .clear   (grant[i]),
        .in_tag  (bus.req_tag[i*TAG_W +: TAG_W]),
        .in_data (bus.req_data[i*DATA_W +: DATA_W]),
        .held_v  (held_v[i]),
        .tag     (held_tag[i]),
        .data    (held_data[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.cdb_valid <= 1'b0;
      bus.cdb_tag   <= '0;
      bus.cdb_data  <= '0;
      bus.cdb_src   <= '0;
      rr_last       <= SRC_W'(NUM_REQ - 1);
    end else if (bus.flush) begin
      bus.cdb_valid <= 1'b0;
    end else if (found) begin
      bus.cdb_valid <= 1'b1;
      bus.cdb_tag   <= held_tag[win];
      bus.cdb_data  <= held_data[win];
      bus.cdb_src   <= win;
      rr_last       <= win;
    end else begin
      bus.cdb_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int N = 3;
  localparam int TW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) bus ();

  cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  // Reference: each requester has a mailbox slot; a pointer remembers who
  // went last; one slot drains per cycle.
  bit          m_full [N];
  int          m_tag  [N];
  int unsigned m_data [N];
  int          m_last;
  bit          m_cv;
  int          m_ct, m_cs;
  int unsigned m_cd;
  int          bcast_cnt;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      int j = (m_last + k) % N;
      if (m_full[j]) return j;
    end
    return -1;
  endfunction

  // One clock: drive inputs, check ready mid-cycle, advance model, check CDB.
  task automatic step(input logic [N-1:0] v, input logic [N*TW-1:0] tg,
                      input logic [N*DW-1:0] dt, input logic fl, input logic r);
    int w;
    logic [N-1:0] rdy;
    rst = r;
    bus.flush = fl;
    bus.req_valid = v;
    bus.req_tag = tg;
    bus.req_data = dt;
    @(negedge clk);
    w = pick();
    for (int i = 0; i < N; i++) rdy[i] = !fl && (!m_full[i] || (i == w));
    chk("req_ready", 64'(bus.req_ready), 64'(rdy));
    if (r) begin
      for (int i = 0; i < N; i++) m_full[i] = 0;
      m_last = N - 1;
      m_cv = 0; m_ct = 0; m_cd = 0; m_cs = 0;
    end else if (fl) begin
      for (int i = 0; i < N; i++) m_full[i] = 0;
      m_cv = 0;
    end else begin
      if (w >= 0) begin
        m_cv = 1; m_ct = m_tag[w]; m_cd = m_data[w]; m_cs = w;
        m_full[w] = 0; m_last = w;
      end else m_cv = 0;
      for (int i = 0; i < N; i++)
        if (v[i] && rdy[i] && tg[i*TW +: TW] != 0) begin
          m_full[i] = 1;
          m_tag[i] = int'(tg[i*TW +: TW]);
          m_data[i] = dt[i*DW +: DW];
        end
    end
    @(posedge clk);
    #1;
    chk("cdb_valid", 64'(bus.cdb_valid), 64'(m_cv));
    if (bus.cdb_valid) bcast_cnt++;
    if (m_cv || r) begin
      chk("cdb_tag", 64'(bus.cdb_tag), 64'(m_ct));
      chk("cdb_data", 64'(bus.cdb_data), 64'(m_cd));
      chk("cdb_src", 64'(bus.cdb_src), 64'(m_cs));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.flush = 0; bus.req_valid = '0; bus.req_tag = '0; bus.req_data = '0;
    for (int i = 0; i < N; i++) begin m_full[i] = 0; m_tag[i] = 0; m_data[i] = 0; end
    m_last = N - 1; m_cv = 0; m_ct = 0; m_cd = 0; m_cs = 0; bcast_cnt = 0;

    // 1. reset then idle
    step('0, '0, '0, 1'b0, 1'b1);
    chk("reset_valid", 64'(bus.cdb_valid), 64'd0);
    chk("reset_ready", 64'(bus.req_ready), 64'b111);
    idle(5);
    chk("idle_no_bcast", 64'(bcast_cnt), 64'd0);

    // 2. single result, two-edge latency then idle
    step(3'b001, {4'd0, 4'd0, 4'd3}, {32'd0, 32'd0, 32'hDEADBEEF}, 1'b0, 1'b0);
    chk("single_lat0", 64'(bus.cdb_valid), 64'd0);
    idle(1);
    chk("single_tag", 64'(bus.cdb_tag), 64'd3);
    chk("single_data", 64'(bus.cdb_data), 64'hDEADBEEF);
    idle(1);
    chk("single_after", 64'(bus.cdb_valid), 64'd0);

    // 3. contention from reset: strict rotation, no gaps
    step('0, '0, '0, 1'b0, 1'b1);
    step(3'b111, {4'd3, 4'd2, 4'd1}, {32'h30, 32'h20, 32'h10}, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(3'b111, {4'd3, 4'd2, 4'd1}, {32'h30, 32'h20, 32'h10}, 1'b0, 1'b0);
      chk("rot_valid", 64'(bus.cdb_valid), 64'd1);
      chk("rot_src", 64'(bus.cdb_src), 64'(k % 3));
    end
    idle(4);

    // 4. back-pressure: req0 and req1 held together with rr_last=2
    step('0, '0, '0, 1'b0, 1'b1);
    step(3'b011, {4'd0, 4'd6, 4'd5}, {32'd0, 32'h66, 32'h55}, 1'b0, 1'b0);
    step(3'b010, {4'd0, 4'd9, 4'd0}, {32'd0, 32'h99, 32'd0}, 1'b0, 1'b0);
    chk("bp_src0", 64'(bus.cdb_src), 64'd0);
    idle(1);
    chk("bp_src1_tag", 64'(bus.cdb_tag), 64'd6);
    idle(2);

    // 5. flush kills both held results
    bcast_cnt = 0;
    step(3'b101, {4'd7, 4'd0, 4'd5}, {32'h77, 32'd0, 32'h55}, 1'b0, 1'b0);
    step(3'b111, {4'd2, 4'd2, 4'd2}, {32'h1, 32'h1, 32'h1}, 1'b1, 1'b0);
    idle(4);
    chk("flush_no_bcast", 64'(bcast_cnt), 64'd0);

    // 6. tag 0 accepted and dropped
    step(3'b010, {4'd0, 4'd0, 4'd0}, {32'd0, 32'h55, 32'd0}, 1'b0, 1'b0);
    idle(4);
    chk("tag0_no_bcast", 64'(bcast_cnt), 64'd0);
    chk("tag0_ready1", 64'(bus.req_ready[1]), 64'd1);

    // random traffic against the reference
    for (int k = 0; k < 400; k++) begin
      logic [N*TW-1:0] tg;
      logic [N*DW-1:0] dt;
      for (int i = 0; i < N; i++) begin
        tg[i*TW +: TW] = TW'($urandom_range(0, 15));
        dt[i*DW +: DW] = $urandom;
      end
      step(N'($urandom_range(0, 7)), tg, dt,
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 99) == 0));
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
